// File: rtl/frame_seq_pkg.sv
// Shared definitions for the hologram frame sequencer: register map,
// CTRL/STATUS bit layout, playback state encoding and helpers.
package frame_seq_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_FRAME  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_PLAY    = 0;
  localparam int CTRL_REVERSE = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_STEP    = 3;
  localparam int CTRL_SYNC    = 4;

  localparam int STAT_PEND = 2;
  localparam int STAT_DONE = 3;

  localparam logic [31:0] MIN_PERIOD = 32'd2;

  typedef enum logic [1:0] {
    ST_PAUSE = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  typedef struct packed {
    logic sync_en;
    logic oneshot;
    logic reverse;
    logic play;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{sync_en: 1'b1, oneshot: 1'b0, reverse: 1'b0, play: 1'b1};

  // Step is a pulse and is never stored, so it always reads back as 0.
  function automatic logic [31:0] ctrl_word(input ctrl_t c);
    logic [31:0] w;
    w               = '0;
    w[CTRL_PLAY]    = c.play;
    w[CTRL_REVERSE] = c.reverse;
    w[CTRL_ONESHOT] = c.oneshot;
    w[CTRL_SYNC]    = c.sync_en;
    return w;
  endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame pacing counter: while enabled it raises expire once every period_i
// cycles; clear restarts the count and suppresses expiry in that cycle.
module frame_timer
  import frame_seq_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        clr_i,
  input  logic [31:0] period_i,
  output logic        expire_o
);

  logic [31:0] count_q, count_d;

  // >= keeps the counter from running away if the period shrinks mid-count.
  assign expire_o = en_i && !clr_i && (count_q >= period_i - 32'd1);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = expire_o ? '0 : count_q + 32'd1;
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Animation playback controller: paces frames, handles play/pause/step,
// reverse and one-shot, and defers frame changes to the theta wrap.
module frame_sequencer
  import frame_seq_pkg::*;
#(
  parameter int CLK_FREQ       = 100_000_000,
  parameter int NUM_FRAMES     = 30,
  parameter int FRAME_SIZE     = 3328,
  parameter int ADDR_W         = $clog2(FRAME_SIZE * NUM_FRAMES),
  parameter int THETA_BITS     = 6,
  parameter int DEFAULT_PERIOD = CLK_FREQ / 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic [31:0]           cfg_rdata,
  input  logic [THETA_BITS-1:0] theta,
  output logic [7:0]            frame_idx,
  output logic [ADDR_W-1:0]     frame_offset,
  output logic                  frame_tick,
  output logic [1:0]            state
);

  localparam logic [7:0] LAST_IDX = 8'(NUM_FRAMES - 1);

  function automatic logic [ADDR_W-1:0] offset_of(input logic [7:0] idx);
    return ADDR_W'(int'(idx) * FRAME_SIZE);
  endfunction

  state_e                state_q, state_d;
  ctrl_t                 ctrl_q, ctrl_d;
  logic [31:0]           period_q, period_d;
  logic                  done_q, done_d;
  logic                  pend_q, pend_d;
  logic [7:0]            pend_idx_q, pend_idx_d;
  logic [ADDR_W-1:0]     pend_off_q, pend_off_d;
  logic [7:0]            frame_idx_q, frame_idx_d;
  logic [ADDR_W-1:0]     frame_off_q, frame_off_d;
  logic                  tick_q;
  logic [31:0]           rdata_q, rdata_d;
  logic [THETA_BITS-1:0] theta_q;

  logic       ctrl_wr, period_wr, frame_wr_ok;
  logic       timer_en, timer_clr, timer_exp;
  logic       step_adv, adv_req, commit, at_end;
  logic       load_en;
  logic [7:0] load_idx, base_idx, next_idx;

  assign ctrl_wr     = cfg_we && (cfg_addr == REG_CTRL);
  assign period_wr   = cfg_we && (cfg_addr == REG_PERIOD);
  assign frame_wr_ok = cfg_we && (cfg_addr == REG_FRAME) && (cfg_wdata < 32'(NUM_FRAMES));

  assign timer_en  = (state_q == ST_PLAY);
  assign timer_clr = period_wr || frame_wr_ok;

  frame_timer u_timer (
    .clk      (clk),
    .reset    (reset),
    .en_i     (timer_en),
    .clr_i    (timer_clr),
    .period_i (period_q),
    .expire_o (timer_exp)
  );

  // A step only counts when the write leaves the sequencer paused.
  assign step_adv = ctrl_wr && cfg_wdata[CTRL_STEP] && !cfg_wdata[CTRL_PLAY]
                    && (state_q != ST_DONE);
  assign adv_req  = timer_exp || step_adv;

  // Advances chain from the pending frame so a burst skips frames instead of queueing.
  assign base_idx = pend_q ? pend_idx_q : frame_idx_q;
  assign at_end   = ctrl_q.reverse ? (base_idx == 8'd0) : (base_idx == LAST_IDX);

  always_comb begin
    next_idx = '0;
    if (ctrl_q.reverse) begin
      next_idx = (base_idx == 8'd0) ? LAST_IDX : base_idx - 8'd1;
    end else begin
      next_idx = (base_idx == LAST_IDX) ? 8'd0 : base_idx + 8'd1;
    end
  end

  assign commit = pend_q && (!ctrl_q.sync_en ||
                  ((theta_q == {THETA_BITS{1'b1}}) && (theta == '0)));

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    period_d    = period_q;
    done_d      = done_q;
    pend_d      = pend_q;
    pend_idx_d  = pend_idx_q;
    pend_off_d  = pend_off_q;
    frame_idx_d = frame_idx_q;
    frame_off_d = frame_off_q;
    load_en     = 1'b0;
    load_idx    = '0;

    if (commit) begin
      frame_idx_d = pend_idx_q;
      frame_off_d = pend_off_q;
      pend_d      = 1'b0;
    end

    if (ctrl_wr) begin
      ctrl_d.play    = cfg_wdata[CTRL_PLAY];
      ctrl_d.reverse = cfg_wdata[CTRL_REVERSE];
      ctrl_d.oneshot = cfg_wdata[CTRL_ONESHOT];
      ctrl_d.sync_en = cfg_wdata[CTRL_SYNC];
      if (cfg_wdata[CTRL_PLAY]) begin
        done_d  = 1'b0;
        state_d = ST_PLAY;
        if (state_q == ST_DONE) begin
          load_en  = 1'b1;
          load_idx = cfg_wdata[CTRL_REVERSE] ? LAST_IDX : 8'd0;
        end
      end else if (state_q == ST_PLAY) begin
        state_d = ST_PAUSE;
      end
    end

    if (period_wr) begin
      period_d = (cfg_wdata < MIN_PERIOD) ? MIN_PERIOD : cfg_wdata;
    end

    // A valid FRAME write overrides any advance landing in the same cycle.
    if (frame_wr_ok) begin
      load_en  = 1'b1;
      load_idx = cfg_wdata[7:0];
    end else if (adv_req && !load_en) begin
      if (ctrl_q.oneshot && at_end) begin
        state_d     = ST_DONE;
        ctrl_d.play = 1'b0;
        done_d      = 1'b1;
      end else begin
        load_en  = 1'b1;
        load_idx = next_idx;
      end
    end

    if (load_en) begin
      pend_d     = 1'b1;
      pend_idx_d = load_idx;
      pend_off_d = offset_of(load_idx);
    end
  end

  always_comb begin
    rdata_d = '0;
    case (cfg_addr)
      REG_CTRL:   rdata_d = ctrl_word(ctrl_q);
      REG_PERIOD: rdata_d = period_q;
      REG_FRAME:  rdata_d = {24'd0, frame_idx_q};
      default: begin
        rdata_d[1:0]      = state_q;
        rdata_d[STAT_PEND] = pend_q;
        rdata_d[STAT_DONE] = done_q;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_PLAY;
      ctrl_q      <= CTRL_RESET;
      period_q    <= 32'(DEFAULT_PERIOD);
      done_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_idx_q  <= '0;
      pend_off_q  <= '0;
      frame_idx_q <= '0;
      frame_off_q <= '0;
      tick_q      <= 1'b0;
      rdata_q     <= '0;
      theta_q     <= '0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      period_q    <= period_d;
      done_q      <= done_d;
      pend_q      <= pend_d;
      pend_idx_q  <= pend_idx_d;
      pend_off_q  <= pend_off_d;
      frame_idx_q <= frame_idx_d;
      frame_off_q <= frame_off_d;
      tick_q      <= commit;
      rdata_q     <= rdata_d;
      theta_q     <= theta;
    end
  end

  assign cfg_rdata    = rdata_q;
  assign frame_idx    = frame_idx_q;
  assign frame_offset = frame_off_q;
  assign frame_tick   = tick_q;
  assign state        = state_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Directed and randomized bench for frame_sequencer; a cycle-level playback
// model built from the behavioural rules predicts every output each cycle.
module tb_frame_sequencer;

  localparam int NF = 4;
  localparam int FS = 8;
  localparam int AW = 5;
  localparam int CF = 100_000_000;
  localparam int DP = CF / 15;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cfg_we = 1'b0;
  logic [1:0]    cfg_addr = 2'd0;
  logic [31:0]   cfg_wdata = 32'd0;
  logic [31:0]   cfg_rdata;
  logic [5:0]    theta = 6'd0;
  logic [7:0]    frame_idx;
  logic [AW-1:0] frame_offset;
  logic          frame_tick;
  logic [1:0]    state;

  int n_checks = 0;
  int n_errors = 0;

  // Reference playback model (post-edge view).
  int          m_st, m_play, m_rev, m_one, m_sync, m_done, m_pend, m_pidx, m_fidx, m_tick, m_thq;
  int unsigned m_period, m_timer;
  logic [31:0] m_rdata;

  always #5 clk = ~clk;

  frame_sequencer #(
    .CLK_FREQ(CF), .NUM_FRAMES(NF), .FRAME_SIZE(FS), .ADDR_W(AW),
    .THETA_BITS(6), .DEFAULT_PERIOD(DP)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata), .theta(theta),
    .frame_idx(frame_idx), .frame_offset(frame_offset),
    .frame_tick(frame_tick), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 1; m_play = 1; m_rev = 0; m_one = 0; m_sync = 1;
    m_period = DP; m_timer = 0; m_done = 0; m_pend = 0; m_pidx = 0;
    m_fidx = 0; m_tick = 0; m_rdata = 0; m_thq = 0;
  endtask

  task automatic model_eval();
    int          n_st, n_play, n_rev, n_one, n_sync, n_done, n_pend, n_pidx, n_fidx;
    int unsigned n_period, n_timer;
    logic [31:0] rd;
    bit          commit, clr, expire, step, load;
    int          base, load_idx;
    n_st = m_st; n_play = m_play; n_rev = m_rev; n_one = m_one; n_sync = m_sync;
    n_done = m_done; n_pend = m_pend; n_pidx = m_pidx; n_fidx = m_fidx;
    n_period = m_period; n_timer = m_timer;
    step = 0; load = 0; load_idx = 0;

    case (cfg_addr)
      2'd0:    rd = 32'(m_play) | (32'(m_rev) << 1) | (32'(m_one) << 2) | (32'(m_sync) << 4);
      2'd1:    rd = m_period;
      2'd2:    rd = 32'(m_fidx);
      default: rd = 32'(m_st) | (32'(m_pend) << 2) | (32'(m_done) << 3);
    endcase

    commit = (m_pend != 0) && (m_sync == 0 || (m_thq == 63 && theta == 6'd0));
    clr    = cfg_we && (cfg_addr == 2'd1 || (cfg_addr == 2'd2 && cfg_wdata < 32'(NF)));
    expire = (m_st == 1) && !clr && (m_timer >= m_period - 1);

    if (commit) begin
      n_fidx = m_pidx;
      n_pend = 0;
    end

    if (cfg_we && cfg_addr == 2'd0) begin
      n_play = int'(cfg_wdata[0]); n_rev = int'(cfg_wdata[1]);
      n_one  = int'(cfg_wdata[2]); n_sync = int'(cfg_wdata[4]);
      if (cfg_wdata[0]) begin
        n_done = 0;
        if (m_st == 2) begin
          load = 1;
          load_idx = cfg_wdata[1] ? NF - 1 : 0;
        end
        n_st = 1;
      end else begin
        if (m_st == 1) n_st = 0;
        if (cfg_wdata[3] && m_st != 2) step = 1;
      end
    end
    if (cfg_we && cfg_addr == 2'd1) n_period = (cfg_wdata < 2) ? 2 : cfg_wdata;

    if (clr) n_timer = 0;
    else if (m_st == 1) n_timer = expire ? 0 : m_timer + 1;

    base = (m_pend != 0) ? m_pidx : m_fidx;
    if (cfg_we && cfg_addr == 2'd2 && cfg_wdata < 32'(NF)) begin
      load = 1;
      load_idx = int'(cfg_wdata);
    end else if (!load && (expire || step)) begin
      if (m_one != 0 && base == (m_rev != 0 ? 0 : NF - 1)) begin
        n_st = 2; n_play = 0; n_done = 1;
      end else begin
        load = 1;
        load_idx = (m_rev != 0) ? (base + NF - 1) % NF : (base + 1) % NF;
      end
    end
    if (load) begin
      n_pend = 1;
      n_pidx = load_idx;
    end

    m_st = n_st; m_play = n_play; m_rev = n_rev; m_one = n_one; m_sync = n_sync;
    m_done = n_done; m_pend = n_pend; m_pidx = n_pidx; m_fidx = n_fidx;
    m_period = n_period; m_timer = n_timer;
    m_tick = commit ? 1 : 0; m_rdata = rd; m_thq = int'(theta);
  endtask

  // One clock: advance the model with the applied inputs, then compare every output.
  task automatic tick();
    if (!reset) model_reset();
    else model_eval();
    @(posedge clk);
    #1;
    check("frame_idx", 32'(frame_idx), 32'(m_fidx));
    check("frame_offset", 32'(frame_offset), 32'(m_fidx * FS));
    check("frame_tick", 32'(frame_tick), 32'(m_tick));
    check("state", 32'(state), 32'(m_st));
    check("cfg_rdata", cfg_rdata, m_rdata);
    cfg_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
  endtask

  task automatic rd(input logic [1:0] a);
    cfg_addr = a;
    tick();
  endtask

  initial begin
    int nt, last, first;
    logic [31:0] d;

    // Reset state
    reset = 1'b0;
    tick(); tick();
    check("rst_frame_idx", 32'(frame_idx), 32'd0);
    check("rst_offset", 32'(frame_offset), 32'd0);
    check("rst_tick", 32'(frame_tick), 32'd0);
    check("rst_state", 32'(state), 32'd1);
    check("rst_rdata", cfg_rdata, 32'd0);
    reset = 1'b1;
    rd(2'd0); check("rst_ctrl", cfg_rdata, 32'h11);
    rd(2'd1); check("rst_period", cfg_rdata, 32'(DP));

    // Free-run, sync off
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h01);
    nt = 0; last = 0;
    for (int c = 0; c < 80 && nt < 4; c++) begin
      tick();
      if (frame_tick) begin
        check("free_idx", 32'(frame_idx), 32'((nt + 1) % NF));
        check("free_off", 32'(frame_offset), 32'(((nt + 1) % NF) * FS));
        if (nt > 0) check("free_gap", 32'(c - last), 32'd10);
        last = c;
        nt++;
      end
    end
    check("free_count", 32'(nt), 32'd4);

    // Sync: hold theta away from the wrap through an expiry, then wrap
    wr(2'd1, 32'd10);
    theta = 6'd17;
    wr(2'd0, 32'h11);
    repeat (10) tick();
    rd(2'd3);
    check("sync_hold_status", cfg_rdata, 32'h5);
    check("sync_hold_idx", 32'(frame_idx), 32'd0);
    theta = 6'd63; tick();
    check("sync_no_early_tick", 32'(frame_tick), 32'd0);
    theta = 6'd0; tick();
    check("sync_commit_idx", 32'(frame_idx), 32'd1);
    check("sync_commit_tick", 32'(frame_tick), 32'd1);
    wr(2'd1, 32'd1000);
    rd(2'd3);
    check("sync_after_status", cfg_rdata, 32'h1);

    // Reverse one-shot
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h07);
    wr(2'd2, 32'd2);
    tick();
    check("rev_load_idx", 32'(frame_idx), 32'd2);
    nt = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (frame_tick) begin
        check("rev_idx", 32'(frame_idx), (nt == 0) ? 32'd1 : 32'd0);
        nt++;
      end
    end
    check("rev_ticks", 32'(nt), 32'd2);
    check("rev_state_done", 32'(state), 32'd2);
    rd(2'd0); check("rev_ctrl", cfg_rdata, 32'h06);
    rd(2'd3); check("rev_status", cfg_rdata, 32'hA);
    wr(2'd0, 32'h03);
    tick();
    check("restart_idx", 32'(frame_idx), 32'd3);
    check("restart_state", 32'(state), 32'd1);

    // Pause with the timer held at 6, then step, then resume
    wr(2'd0, 32'h01);
    wr(2'd1, 32'd10);
    repeat (5) tick();
    wr(2'd0, 32'h00);
    nt = 0;
    repeat (50) begin
      tick();
      if (frame_tick) nt++;
    end
    check("pause_ticks", 32'(nt), 32'd0);
    check("pause_state", 32'(state), 32'd0);
    wr(2'd0, 32'h08);
    tick();
    check("step_tick", 32'(frame_tick), 32'd1);
    check("step_idx", 32'(frame_idx), 32'd0);
    wr(2'd0, 32'h01);
    first = 0;
    for (int c = 1; c <= 8 && first == 0; c++) begin
      tick();
      if (frame_tick) first = c;
    end
    check("resume_latency", 32'(first), 32'd5);

    // Out-of-range FRAME write is ignored
    wr(2'd0, 32'h00);
    wr(2'd2, 32'd4);
    tick(); tick();
    check("frame_bad_idx", 32'(frame_idx), 32'd1);
    rd(2'd3); check("frame_bad_status", cfg_rdata, 32'h0);

    // FRAME write on an expiry cycle wins and restarts the timer
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h01);
    repeat (9) tick();
    wr(2'd2, 32'd2);
    tick();
    check("frame_exp_idx", 32'(frame_idx), 32'd2);
    check("frame_exp_tick", 32'(frame_tick), 32'd1);
    first = 0;
    for (int c = 1; c <= 20 && first == 0; c++) begin
      tick();
      if (frame_tick) first = c;
    end
    check("frame_exp_restart", 32'(first), 32'd10);
    check("frame_exp_next", 32'(frame_idx), 32'd3);

    // Minimum period clamp
    wr(2'd1, 32'd0);
    rd(2'd1); check("period_clamp", cfg_rdata, 32'd2);

    // Reset while a frame is pending
    wr(2'd1, 32'd10);
    theta = 6'd17;
    wr(2'd0, 32'h11);
    repeat (11) tick();
    rd(2'd3); check("pre_reset_status", cfg_rdata, 32'h5);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("post_reset_idx", 32'(frame_idx), 32'd0);
    rd(2'd3); check("post_reset_status", cfg_rdata, 32'h1);
    rd(2'd1); check("post_reset_period", cfg_rdata, 32'(DP));
    rd(2'd0); check("post_reset_ctrl", cfg_rdata, 32'h11);

    // Randomized traffic against the model
    wr(2'd1, 32'd4);
    wr(2'd0, 32'h01);
    for (int c = 0; c < 3000; c++) begin
      theta = theta + 6'($urandom_range(0, 2));
      reset = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_we = 1'b1;
        cfg_addr = 2'($urandom_range(0, 3));
        case (cfg_addr)
          2'd0: begin
            d = 32'($urandom_range(0, 31));
            if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
          end
          2'd1:    d = 32'($urandom_range(0, 20));
          2'd2:    d = 32'($urandom_range(0, 6));
          default: d = $urandom;
        endcase
        cfg_wdata = d;
      end else begin
        cfg_addr = 2'($urandom_range(0, 3));
      end
      tick();
    end
    reset = 1'b1;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
